// File: rtl/green_blend_pipe_pkg.sv
// Shared defaults and lane-slice helper for the CFA green blend pipeline.
// The macro slices lane k of a packed multi-lane bus whose lanes are w bits wide.
`ifndef GBP_LANE
`define GBP_LANE(k, w) (k)*(w) +: (w)
`endif

package green_blend_pipe_pkg;

  localparam int DEF_PIXEL_W  = 12;
  localparam int DEF_WEIGHT_W = 8;
  localparam int DEF_FRAC_W   = 8;
  localparam int DEF_LANES    = 1;
  localparam int DEF_STAT_W   = 16;

  // Control that travels with a beat through the product stage.
  typedef struct packed {
    logic valid;
    logic rnd;
  } beat_ctl_t;

endpackage

// File: rtl/green_blend_pipe_if.sv
// Stream bundle for the green blend pipe: input beat, output beat and both handshakes.
interface green_blend_pipe_if #(
  parameter int LANES    = green_blend_pipe_pkg::DEF_LANES,
  parameter int PIXEL_W  = green_blend_pipe_pkg::DEF_PIXEL_W,
  parameter int WEIGHT_W = green_blend_pipe_pkg::DEF_WEIGHT_W
);
  logic                         in_valid;
  logic                         in_ready;
  logic                         round_en;
  logic [LANES*WEIGHT_W-1:0]    w_s;
  logic [LANES*WEIGHT_W-1:0]    w_f;
  logic [LANES*(PIXEL_W+1)-1:0] green_s;
  logic [LANES*(PIXEL_W+1)-1:0] green_f;
  logic                         out_valid;
  logic                         out_ready;
  logic [LANES*PIXEL_W-1:0]     green;

  modport master (
    output in_valid, round_en, w_s, w_f, green_s, green_f, out_ready,
    input  in_ready, out_valid, green
  );

  modport slave (
    input  in_valid, round_en, w_s, w_f, green_s, green_f, out_ready,
    output in_ready, out_valid, green
  );
endinterface

// File: rtl/green_blend_pipe_lane.sv
// One lane of the green blend: S1 products, S2 sum+round, S3 shift/clamp.
// Clip flags describe the beat currently in S2, i.e. the one S3 loads next.
module green_blend_lane
  import green_blend_pipe_pkg::*;
#(
  parameter int PIXEL_W  = DEF_PIXEL_W,
  parameter int WEIGHT_W = DEF_WEIGHT_W,
  parameter int FRAC_W   = DEF_FRAC_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      adv_i,
  input  logic                      s3_load_i,
  input  logic                      rnd_i,
  input  logic [WEIGHT_W-1:0]       w_s_i,
  input  logic [WEIGHT_W-1:0]       w_f_i,
  input  logic signed [PIXEL_W:0]   green_s_i,
  input  logic signed [PIXEL_W:0]   green_f_i,
  output logic [PIXEL_W-1:0]        green_o,
  output logic                      clip_lo_o,
  output logic                      clip_hi_o
);
  localparam int PROD_W = PIXEL_W + WEIGHT_W + 1;
  localparam int SUM_W  = PROD_W + 1;
  localparam logic signed [SUM_W-1:0] HALF = SUM_W'(1 << (FRAC_W - 1));

  logic signed [PROD_W-1:0] ps_d, pf_d, ps_q, pf_q;
  logic signed [SUM_W-1:0]  sum_d, sum_q, r;
  logic [PIXEL_W-1:0]       green_d, green_q;

  always_comb begin
    // NOTE: every always_comb output gets a value on every path first, so no latch is inferred.
    ps_d  = PROD_W'(green_s_i) * PROD_W'($signed({1'b0, w_s_i}));
    pf_d  = PROD_W'(green_f_i) * PROD_W'($signed({1'b0, w_f_i}));
    sum_d = SUM_W'(ps_q) + SUM_W'(pf_q);
    if (rnd_i) sum_d = sum_d + HALF;

    r         = sum_q >>> FRAC_W;
    clip_lo_o = r[SUM_W-1];
    clip_hi_o = !r[SUM_W-1] && (|r[SUM_W-2:PIXEL_W]);
    green_d   = r[PIXEL_W-1:0];
    if (clip_lo_o)      green_d = '0;
    else if (clip_hi_o) green_d = '1;
  end

  // NOTE: pure datapath registers carry no reset; the valid bits in the top decide what is real.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (adv_i) begin
      ps_q  <= ps_d;
      pf_q  <= pf_d;
      sum_q <= sum_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)            green_q <= '0;
    else if (s3_load_i) green_q <= green_d;
  end

  assign green_o = green_q;
endmodule

// File: rtl/green_blend_pipe.sv
// Multi-lane pipelined green blend: handshake, stage valids, round_en pipe and clip counters.
// All stages advance together whenever the output register is empty or being drained.
module green_blend_pipe
  import green_blend_pipe_pkg::*;
#(
  parameter int PIXEL_W  = DEF_PIXEL_W,
  parameter int WEIGHT_W = DEF_WEIGHT_W,
  parameter int FRAC_W   = DEF_FRAC_W,
  parameter int LANES    = DEF_LANES,
  parameter int STAT_W   = DEF_STAT_W
) (
  input  logic              clk,
  input  logic              rst,
  green_blend_pipe_if.slave bus,
  input  logic              clr_stats,
  output logic [STAT_W-1:0] clip_lo_cnt,
  output logic [STAT_W-1:0] clip_hi_cnt
);
  beat_ctl_t         s1_d, s1_q;
  logic              v2_d, v2_q, v3_d, v3_q;
  logic [STAT_W-1:0] lo_cnt_d, lo_cnt_q, hi_cnt_d, hi_cnt_q;
  logic [LANES-1:0]  lane_lo, lane_hi;
  logic              advance, s3_load;

  assign advance = !v3_q || bus.out_ready;
  assign s3_load = advance && v2_q;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    green_blend_lane #(
      .PIXEL_W (PIXEL_W),
      .WEIGHT_W(WEIGHT_W),
      .FRAC_W  (FRAC_W)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .adv_i    (advance),
      .s3_load_i(s3_load),
      .rnd_i    (s1_q.rnd),
      .w_s_i    (bus.w_s[`GBP_LANE(k, WEIGHT_W)]),
      .w_f_i    (bus.w_f[`GBP_LANE(k, WEIGHT_W)]),
      .green_s_i(bus.green_s[`GBP_LANE(k, PIXEL_W + 1)]),
      .green_f_i(bus.green_f[`GBP_LANE(k, PIXEL_W + 1)]),
      .green_o  (bus.green[`GBP_LANE(k, PIXEL_W)]),
      .clip_lo_o(lane_lo[k]),
      .clip_hi_o(lane_hi[k])
    );
  end

  always_comb begin
    s1_d = s1_q;
    v2_d = v2_q;
    v3_d = v3_q;
    if (advance) begin
      s1_d = '{valid: bus.in_valid, rnd: bus.round_en};
      v2_d = s1_q.valid;
      v3_d = v2_q;
    end
  end

  // Saturating counters; a clear wins over an increment in the same cycle.
  always_comb begin
    lo_cnt_d = lo_cnt_q;
    hi_cnt_d = hi_cnt_q;
    if (s3_load && (|lane_lo) && (lo_cnt_q != {STAT_W{1'b1}})) lo_cnt_d = lo_cnt_q + STAT_W'(1);
    if (s3_load && (|lane_hi) && (hi_cnt_q != {STAT_W{1'b1}})) hi_cnt_d = hi_cnt_q + STAT_W'(1);
    if (clr_stats) begin
      lo_cnt_d = '0;
      hi_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q     <= '0;
      v2_q     <= 1'b0;
      v3_q     <= 1'b0;
      lo_cnt_q <= '0;
      hi_cnt_q <= '0;
    end else begin
      s1_q     <= s1_d;
      v2_q     <= v2_d;
      v3_q     <= v3_d;
      lo_cnt_q <= lo_cnt_d;
      hi_cnt_q <= hi_cnt_d;
    end
  end

  assign bus.in_ready  = advance;
  assign bus.out_valid = v3_q;
  assign clip_lo_cnt   = lo_cnt_q;
  assign clip_hi_cnt   = hi_cnt_q;
endmodule

// File: tb/tb_green_blend_pipe.sv
// Directed bench: single-lane vector table plus stall, 4-lane saturation, clear and reset sequences.
module tb_green_blend_pipe;
  typedef struct packed {
    logic [12:0] gs;
    logic [12:0] gf;
    logic [7:0]  ws;
    logic [7:0]  wf;
    logic        rnd;
    logic [11:0] exp_g;
    logic        exp_lo;
    logic        exp_hi;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, rst4, clr0, clr4;
  logic [15:0] lo0, hi0;
  logic [3:0]  lo4, hi4;

  green_blend_pipe_if #(.LANES(1), .PIXEL_W(12), .WEIGHT_W(8)) bus0 ();
  green_blend_pipe_if #(.LANES(4), .PIXEL_W(12), .WEIGHT_W(8)) bus4 ();

  green_blend_pipe #(.PIXEL_W(12), .WEIGHT_W(8), .FRAC_W(8), .LANES(1), .STAT_W(16)) u0 (
    .clk(clk), .rst(rst0), .bus(bus0), .clr_stats(clr0), .clip_lo_cnt(lo0), .clip_hi_cnt(hi0)
  );

  green_blend_pipe #(.PIXEL_W(12), .WEIGHT_W(8), .FRAC_W(8), .LANES(4), .STAT_W(4)) u4 (
    .clk(clk), .rst(rst4), .bus(bus4), .clr_stats(clr4), .clip_lo_cnt(lo4), .clip_hi_cnt(hi4)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Fixed 4-lane beat: lane0 clips high, lane1 clips low, lane2 = 1500, lane3 = rnd ? 1 : 0.
  task automatic drive4(input logic valid, input logic rnd);
    bus4.in_valid = valid;
    bus4.round_en = rnd;
    bus4.green_s  = {13'd1, 13'd1000, 13'h1FCE, 13'd4095};
    bus4.w_s      = {8'd128, 8'd128, 8'd200, 8'd255};
    bus4.green_f  = {13'd0, 13'd2000, 13'd10, 13'd4095};
    bus4.w_f      = {8'd0, 8'd128, 8'd56, 8'd255};
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t     vecs[12];
  logic [11:0] exp_q[$];
  logic [47:0] exp4;
  int lat, sent, got, nout;
  logic seen;

  initial begin
    // gs, gf, ws, wf, rnd, green, lo, hi   (13'h1FCE=-50, 13'h1FFF=-1, 13'h1000=-4096)
    vecs[0]  = '{13'd1000,  13'd2000,  8'd128, 8'd128, 1'b0, 12'd1500, 1'b0, 1'b0};
    vecs[1]  = '{13'h1FCE,  13'd10,    8'd200, 8'd56,  1'b0, 12'd0,    1'b1, 1'b0};
    vecs[2]  = '{13'd4095,  13'd4095,  8'd255, 8'd255, 1'b0, 12'hFFF,  1'b0, 1'b1};
    vecs[3]  = '{13'd1,     13'd0,     8'd128, 8'd0,   1'b0, 12'd0,    1'b0, 1'b0};
    vecs[4]  = '{13'd1,     13'd0,     8'd128, 8'd0,   1'b1, 12'd1,    1'b0, 1'b0};
    vecs[5]  = '{13'd4095,  13'd17,    8'd255, 8'd255, 1'b0, 12'hFFF,  1'b0, 1'b0};
    vecs[6]  = '{13'd4095,  13'd18,    8'd255, 8'd255, 1'b0, 12'hFFF,  1'b0, 1'b1};
    vecs[7]  = '{13'h1FFF,  13'd0,     8'd1,   8'd0,   1'b0, 12'd0,    1'b1, 1'b0};
    vecs[8]  = '{13'h1FFF,  13'd0,     8'd1,   8'd0,   1'b1, 12'd0,    1'b0, 1'b0};
    vecs[9]  = '{13'h1000,  13'h1000,  8'd255, 8'd255, 1'b1, 12'd0,    1'b1, 1'b0};
    vecs[10] = '{13'd2000,  13'd1000,  8'd77,  8'd179, 1'b1, 12'd1301, 1'b0, 1'b0};
    vecs[11] = '{13'd2000,  13'd1000,  8'd77,  8'd179, 1'b0, 12'd1300, 1'b0, 1'b0};

    rst0 = 1'b1; rst4 = 1'b1; clr0 = 1'b0; clr4 = 1'b0;
    bus0.in_valid = 1'b0; bus0.round_en = 1'b0; bus0.out_ready = 1'b1;
    bus0.w_s = '0; bus0.w_f = '0; bus0.green_s = '0; bus0.green_f = '0;
    drive4(1'b0, 1'b0);
    bus4.out_ready = 1'b1;
    repeat (3) tick();
    rst0 = 1'b0; rst4 = 1'b0;
    tick();

    check("reset_out_valid0", bus0.out_valid, 0);
    check("reset_green0",     bus0.green, 0);
    check("reset_in_ready0",  bus0.in_ready, 1);
    check("reset_lo0",        lo0, 0);
    check("reset_hi0",        hi0, 0);
    check("reset_out_valid4", bus4.out_valid, 0);
    check("reset_green4",     bus4.green, 0);
    check("reset_cnt4",       {lo4, hi4}, 0);

    // Single-beat vectors: latency, value and per-beat clip counts.
    foreach (vecs[i]) begin
      clr0 = 1'b1; tick(); clr0 = 1'b0;
      bus0.in_valid = 1'b1;
      bus0.round_en = vecs[i].rnd;
      bus0.green_s  = vecs[i].gs;
      bus0.green_f  = vecs[i].gf;
      bus0.w_s      = vecs[i].ws;
      bus0.w_f      = vecs[i].wf;
      #1;
      check($sformatf("vec%0d_in_ready", i), bus0.in_ready, 1);
      tick();
      bus0.in_valid = 1'b0;
      lat = 1;
      while (!bus0.out_valid && lat < 8) begin
        tick();
        lat++;
      end
      check($sformatf("vec%0d_latency", i), lat, 3);
      check($sformatf("vec%0d_green", i), bus0.green, vecs[i].exp_g);
      check($sformatf("vec%0d_clip_lo", i), lo0, {15'd0, vecs[i].exp_lo});
      check($sformatf("vec%0d_clip_hi", i), hi0, {15'd0, vecs[i].exp_hi});
      tick();
    end

    // Back-to-back beats carry their own round_en.
    bus0.green_s = 13'd1; bus0.green_f = 13'd0; bus0.w_s = 8'd128; bus0.w_f = 8'd0;
    bus0.in_valid = 1'b1; bus0.round_en = 1'b0; tick();
    bus0.round_en = 1'b1; tick();
    bus0.in_valid = 1'b0; bus0.round_en = 1'b0;
    tick();
    check("b2b_first_valid", bus0.out_valid, 1);
    check("b2b_first_green", bus0.green, 0);
    tick();
    check("b2b_second_valid", bus0.out_valid, 1);
    check("b2b_second_green", bus0.green, 1);
    tick();
    check("b2b_drained", bus0.out_valid, 0);

    // 10-beat stream, out_ready low in cycles 4..6.
    sent = 0; got = 0;
    for (int c = 0; c < 60 && got < 10; c++) begin
      bus0.out_ready = !(c >= 4 && c <= 6);
      bus0.in_valid  = (sent < 10);
      bus0.round_en  = 1'b0;
      bus0.green_s   = 13'(20 * (sent + 1));
      bus0.green_f   = 13'd0;
      bus0.w_s       = 8'd128;
      bus0.w_f       = 8'd0;
      #1;
      if (c >= 4 && c <= 6) begin
        check($sformatf("stall_in_ready_c%0d", c), bus0.in_ready, 0);
        check($sformatf("stall_out_valid_c%0d", c), bus0.out_valid, 1);
        if (exp_q.size() > 0)
          check($sformatf("stall_hold_c%0d", c), bus0.green, exp_q[0]);
      end
      if (bus0.in_valid && bus0.in_ready) begin
        exp_q.push_back(12'(10 * (sent + 1)));
        sent++;
      end
      if (bus0.out_valid && bus0.out_ready) begin
        if (exp_q.size() == 0) check("stream_unexpected_beat", 1, 0);
        else check($sformatf("stream_beat%0d", got), bus0.green, exp_q.pop_front());
        got++;
      end
      tick();
    end
    bus0.in_valid = 1'b0; bus0.out_ready = 1'b1;
    check("stream_sent", sent, 10);
    check("stream_got", got, 10);
    check("stream_leftover", exp_q.size(), 0);

    // 4 lanes, 16 clipping beats: both 4-bit counters stick at 15.
    exp4 = {12'd1, 12'd1500, 12'd0, 12'hFFF};
    clr4 = 1'b1; tick(); clr4 = 1'b0;
    nout = 0;
    for (int c = 0; c < 24; c++) begin
      drive4(c < 16, 1'b1);
      #1;
      if (bus4.out_valid && bus4.out_ready) begin
        check($sformatf("lanes4_beat%0d", nout), bus4.green, exp4);
        nout++;
      end
      tick();
    end
    drive4(1'b0, 1'b0);
    check("lanes4_out_count", nout, 16);
    check("sat_clip_lo", lo4, 15);
    check("sat_clip_hi", hi4, 15);

    // clr_stats coincident with the S3 load of a clipping beat.
    drive4(1'b1, 1'b0); tick();
    drive4(1'b0, 1'b0); tick();
    clr4 = 1'b1; tick(); clr4 = 1'b0;
    check("clr_coincident_valid", bus4.out_valid, 1);
    check("clr_coincident_green", bus4.green, {12'd0, 12'd1500, 12'd0, 12'hFFF});
    check("clr_coincident_cnt", {lo4, hi4}, 0);
    tick();
    drive4(1'b1, 1'b0); tick();
    drive4(1'b0, 1'b0);
    repeat (3) tick();
    check("post_clr_cnt", {lo4, hi4}, {4'd1, 4'd1});

    // Reset with two beats in flight: nothing comes out.
    drive4(1'b1, 1'b1); tick();
    tick();
    drive4(1'b0, 1'b0);
    rst4 = 1'b1; tick(); rst4 = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (bus4.out_valid) seen = 1'b1;
      tick();
    end
    check("rst_no_output", seen, 0);
    check("rst_green", bus4.green, 0);
    check("rst_cnt", {lo4, hi4}, 0);
    check("rst_in_ready", bus4.in_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
